// File: rtl/seg_scan_capture.sv
// Receive-side sampler for a multiplexed 4-digit active-low 7-segment bus.
// Accepts a pattern once it has been stable for STABLE_CYCLES samples and decodes it per digit.
module seg_scan_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  valid,
    output logic        frame_done,
    output logic        err,
    output logic [1:0]  err_digit
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]       r_seg_q;
    logic [3:0]       r_an_q;
    logic [6:0]       r_prev_seg;
    logic [3:0]       r_prev_an;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_mask;
    logic [15:0]      r_digits;
    logic [3:0]       r_valid;
    logic             r_frame_done;
    logic             r_err;
    logic [1:0]       r_err_digit;

    logic [3:0]       w_an_sel;
    logic             w_sel_ok;
    logic             w_same;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_accept;
    logic [1:0]       w_idx;
    logic [3:0]       w_sel_bit;
    logic [3:0]       w_code;
    logic             w_code_ok;
    logic [3:0]       w_mask_base;

    assign w_an_sel  = ~r_an_q;
    assign w_sel_ok  = (w_an_sel != 4'd0) && ((w_an_sel & (w_an_sel - 4'd1)) == 4'd0);
    assign w_same    = ({r_an_q, r_seg_q} == {r_prev_an, r_prev_seg});
    assign w_accept  = w_sel_ok && w_same && (r_cnt == CNT_LAST);
    assign w_sel_bit = 4'b0001 << w_idx;
    // A full mask is reported and cleared one edge after the last capture.
    assign w_mask_base = (r_mask == 4'hF) ? 4'h0 : r_mask;

    always_comb begin
        w_cnt_next = r_cnt;
        if (!w_sel_ok) begin
            w_cnt_next = '0;
        end else if (w_same) begin
            if (r_cnt != CNT_FULL) begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end else begin
            w_cnt_next = CNT_W'(1);
        end
    end

    always_comb begin
        w_idx = 2'd0;
        if (!r_an_q[0]) begin
            w_idx = 2'd0;
        end else if (!r_an_q[1]) begin
            w_idx = 2'd1;
        end else if (!r_an_q[2]) begin
            w_idx = 2'd2;
        end else begin
            w_idx = 2'd3;
        end
    end

    always_comb begin
        w_code    = 4'hF;
        w_code_ok = 1'b1;
        case (r_seg_q)
            7'b1000000: w_code = 4'h0;
            7'b1111001: w_code = 4'h1;
            7'b0100100: w_code = 4'h2;
            7'b0110000: w_code = 4'h3;
            7'b0011001: w_code = 4'h4;
            7'b0010010: w_code = 4'h5;
            7'b0000010: w_code = 4'h6;
            7'b1111000: w_code = 4'h7;
            7'b0000000: w_code = 4'h8;
            7'b0011000: w_code = 4'h9;
            7'b0001000: w_code = 4'hA;
            7'b1111111: w_code = 4'hF;
            default:    w_code_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_q      <= 7'h7F;
            r_an_q       <= 4'hF;
            r_prev_seg   <= 7'h7F;
            r_prev_an    <= 4'hF;
            r_cnt        <= '0;
            r_mask       <= 4'h0;
            r_digits     <= 16'hFFFF;
            r_valid      <= 4'h0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_err_digit  <= 2'd0;
        end else begin
            r_seg_q      <= seg;
            r_an_q       <= an;
            r_prev_seg   <= r_seg_q;
            r_prev_an    <= r_an_q;
            r_cnt        <= w_cnt_next;
            r_frame_done <= (r_mask == 4'hF);
            r_err        <= w_accept && !w_code_ok;
            r_mask       <= w_accept ? (w_mask_base | w_sel_bit) : w_mask_base;
            if (w_accept) begin
                if (w_code_ok) begin
                    r_digits[{w_idx, 2'b00} +: 4] <= w_code;
                    r_valid[w_idx]                <= 1'b1;
                end else begin
                    r_valid[w_idx] <= 1'b0;
                    r_err_digit    <= w_idx;
                end
            end
        end
    end

    assign digits     = r_digits;
    assign valid      = r_valid;
    assign frame_done = r_frame_done;
    assign err        = r_err;
    assign err_digit  = r_err_digit;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: run-length reference model feeding an expected-snapshot queue,
// a negedge monitor popping on every output change, plus directed point checks.
module tb_seg_scan_capture;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic        frame_done;
    logic        err;
    logic [1:0]  err_digit;

    always #5 clk = ~clk;

    seg_scan_capture #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .seg(seg), .an(an),
        .digits(digits), .valid(valid), .frame_done(frame_done),
        .err(err), .err_digit(err_digit)
    );

    int checks = 0;
    int errors = 0;

    // Snapshot layout: {digits, valid, err_digit, err, frame_done}
    logic [23:0] exp_q[$];
    logic [23:0] exp_s;
    logic [23:0] mon_last;
    bit          mon_en = 1'b0;

    logic [6:0] pat_tab [0:10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0011000, 7'b0001000};

    // Reference model state
    logic [15:0] m_digits;
    logic [3:0]  m_valid;
    logic [1:0]  m_err_digit;
    logic        m_err;
    logic        m_fd;
    logic [3:0]  m_mask;
    logic [10:0] m_prev;
    int          m_run;
    bit          m_pending;
    logic [10:0] m_acc_val;

    function automatic logic [4:0] decode(input logic [6:0] s);
        if (s == 7'h7F) return {1'b1, 4'hF};
        for (int i = 0; i < 11; i++) begin
            if (pat_tab[i] == s) return {1'b1, 4'(i)};
        end
        return 5'b0;
    endfunction

    function automatic bit one_selected(input logic [3:0] a);
        return $countones(~a) == 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_digits = 16'hFFFF; m_valid = 4'h0; m_err_digit = 2'd0;
        m_err = 1'b0; m_fd = 1'b0; m_mask = 4'h0;
        m_prev = 11'h7FF; m_run = 0; m_pending = 1'b0;
    endtask

    task automatic model_accept();
        logic [4:0] dc;
        int idx;
        idx = 0;
        for (int i = 0; i < 4; i++) if (!m_acc_val[7 + i]) idx = i;
        dc = decode(m_acc_val[6:0]);
        if (dc[4]) begin
            m_digits[idx*4 +: 4] = dc[3:0];
            m_valid[idx] = 1'b1;
        end else begin
            m_valid[idx] = 1'b0;
            m_err = 1'b1;
            m_err_digit = 2'(idx);
        end
        m_mask[idx] = 1'b1;
    endtask

    // One clock of stimulus; the model advances by the same edge.
    task automatic tick(input logic r, input logic [3:0] a, input logic [6:0] s);
        logic [23:0] snap;
        @(negedge clk);
        rst = r; an = a; seg = s;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            m_err = 1'b0;
            m_fd  = (m_mask == 4'hF);
            if (m_fd) m_mask = 4'h0;
            if (m_pending) begin
                model_accept();
                m_pending = 1'b0;
            end
            if (!one_selected(a)) m_run = 0;
            else if ({a, s} == m_prev) m_run++;
            else m_run = 1;
            m_prev = {a, s};
            if (one_selected(a) && m_run == STABLE) begin
                m_pending = 1'b1;
                m_acc_val = {a, s};
            end
        end
        snap = {m_digits, m_valid, m_err_digit, m_err, m_fd};
        if (snap !== exp_s) exp_q.push_back(snap);
        exp_s = snap;
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) tick(1'b0, a, s);
    endtask

    always @(negedge clk) begin
        logic [23:0] cur;
        logic [23:0] e;
        if (mon_en) begin
            cur = {digits, valid, err_digit, err, frame_done};
            if (cur !== mon_last) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change got=%h", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL scoreboard got=%h exp=%h", cur, e);
                    end
                end
                mon_last = cur;
            end
        end
    end

    initial begin
        rst = 1'b1; an = 4'hF; seg = 7'h7F;
        exp_s = 'x;
        model_reset();
        tick(1'b1, 4'hF, 7'h7F);
        tick(1'b1, 4'hF, 7'h7F);
        #1;
        chk("reset_digits", 32'(digits), 32'hFFFF);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_frame_done", 32'(frame_done), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        chk("reset_err_digit", 32'(err_digit), 32'h0);
        exp_q.delete();
        mon_last = exp_s;
        mon_en = 1'b1;

        // Latency: capture lands on edge STABLE+1, never repeats while held
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 4'b1110, 7'b0100100);
            #1;
            if (i == STABLE) chk("latency_before", 32'(valid), 32'h0);
            if (i == STABLE + 1) begin
                chk("latency_valid", 32'(valid), 32'h1);
                chk("latency_digit", 32'(digits[3:0]), 32'h2);
            end
        end
        chk("hold_no_err", 32'(err), 32'h0);

        // Full scan 1, 9, A, blank
        hold(4'b1110, 7'b1111001, 6);
        hold(4'b1101, 7'b0011000, 6);
        hold(4'b1011, 7'b0001000, 6);
        hold(4'b0111, 7'b1111111, 6);
        hold(4'hF, 7'h7F, 3);
        chk("scan_digits", 32'(digits), 32'hFA91);
        chk("scan_valid", 32'(valid), 32'hF);

        // Unmappable pattern on digit 2
        hold(4'b1011, 7'b1010101, 6);
        chk("bad_err_digit", 32'(err_digit), 32'h2);
        chk("bad_valid", 32'(valid), 32'hB);
        chk("bad_digits", 32'(digits), 32'hFA91);

        // Unstable pattern never captured
        for (int i = 0; i < 10; i++) hold(4'b1110, (i % 2) ? 7'b0000000 : 7'b1000000, 3);
        chk("toggle_digits", 32'(digits), 32'hFA91);
        chk("toggle_valid", 32'(valid), 32'hB);

        // Illegal selects never captured
        hold(4'b1100, 7'b1111001, 20);
        hold(4'b1111, 7'b1111001, 20);
        chk("badsel_digits", 32'(digits), 32'hFA91);
        chk("badsel_valid", 32'(valid), 32'hB);
        chk("badsel_err", 32'(err), 32'h0);

        // Mid-frame reset aborts the partial frame
        tick(1'b1, 4'hF, 7'h7F);
        hold(4'b1110, 7'b0110000, 6);
        hold(4'b1101, 7'b0011001, 6);
        tick(1'b1, 4'hF, 7'h7F);
        #1;
        chk("midreset_digits", 32'(digits), 32'hFFFF);
        chk("midreset_valid", 32'(valid), 32'h0);
        hold(4'b1011, 7'b0010010, 6);
        hold(4'b0111, 7'b0000010, 6);
        hold(4'b1110, 7'b1111000, 6);
        hold(4'b1101, 7'b0000000, 6);
        hold(4'hF, 7'h7F, 3);
        chk("refill_digits", 32'(digits), 32'h6587);

        // Randomized runs
        for (int n = 0; n < 250; n++) begin
            logic [3:0] a;
            logic [6:0] s;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) a = 4'hF;
            else if (sel == 1) a = 4'($urandom_range(0, 15));
            else a = ~(4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) s = pat_tab[$urandom_range(0, 10)];
            else if ($urandom_range(0, 1) == 0) s = 7'h7F;
            else s = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 39) == 0) tick(1'b1, a, s);
            hold(a, s, $urandom_range(1, 8));
        end

        hold(4'hF, 7'h7F, 10);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side counterpart of the team's hex-to-7-segment driver.
- Samples a multiplexed 4-digit 7-segment bus: active-low segment lines plus active-low digit anodes.
- Accepts a segment pattern only once it has been stable long enough, then maps it back to a 4-bit code per digit.
- Used in loopback self-test and board bring-up to check what the display path actually drives.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted; legal range 2..255.
- CNT_W, 8, width of the stability counter; must hold STABLE_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- seg  in  7  segment lines, active-low; bit0=a … bit6=g.
- an  in  4  digit anodes, active-low; an[i]=0 selects digit i.
- digits  out  16  captured codes; digit i in bits [4i+3:4i].
- valid  out  4  valid[i]=1 when digit i holds a code from a legal pattern.
- frame_done  out  1  one-cycle pulse when all four digits have been captured since the last pulse.
- err  out  1  one-cycle pulse on acceptance of an unmappable pattern.
- err_digit  out  2  index of the digit that caused the last err; holds its value.

Behaviour:
- Reset (rst=1 at a rising edge) sets: digits=16'hFFFF, valid=0, frame_done=0, err=0, err_digit=0, input flops to all-ones, counter=0, capture mask=0. Reset takes priority over every other event and aborts any partial frame.
- Input stage: seg and an are registered once (seg_q, an_q) before any use. No comparison ever uses the raw inputs.
- Select check: an_q is legal only if exactly one bit is 0. All-ones (blanking) or multiple zeros clear the counter to 0; no capture happens.
- Stability counter, for a legal an_q:
  - If {an_q, seg_q} equals the previous sample, the counter increments, saturating at STABLE_CYCLES.
  - Otherwise the counter loads 1.
- Accept event: fires on the single cycle the counter steps from STABLE_CYCLES-1 to STABLE_CYCLES. It never fires again while saturated. A new accept needs a change, then stability again.
- Latency: with seg/an held constant from input cycle 0, the digit register updates on rising edge STABLE_CYCLES+1 (1 edge for the input stage, STABLE_CYCLES edges for stability).
- Decode map (seg_q pattern → code):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4
  - 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0011000→9
  - 0001000→A
  - 1111111 (blank) → F; this counts as legal.
- On accept of digit i (i = index of the low bit of an_q):
  - Legal pattern: digits[i]=code, valid[i]=1, mask[i]=1.
  - Illegal pattern: digits[i] keeps its old value; valid[i]=0; mask[i]=1; err=1 for one cycle; err_digit=i.
- Frame: when the mask would become 4'b1111, frame_done pulses on the edge after the last capture and the mask clears. Re-capturing an already-set digit before the frame completes updates that digit but does not advance the frame.
- Simultaneous events: an accept on the same cycle the mask clears starts the next frame with that digit's bit set.
- All outputs are registered; none combinationally follow seg or an.

Test Plan:
- Reset, then an=4'b1110, seg=7'b0100100 held 10 cycles → digits[3:0]=2 and valid=0001 at edge 5 (STABLE_CYCLES=4); no err; pattern held longer → no repeat accept.
- Scan an=1110,1101,1011,0111 with patterns for 1, 9, A, blank, each held 6 cycles → digits=16'hFA91, valid=4'hF, one frame_done pulse one edge after the 4th capture.
- an=1011, seg=7'b1010101 held 6 cycles → err pulse, err_digit=2, valid[2]=0, digits[11:8] unchanged.
- an=1110, seg toggling between 0 and 8 patterns every 3 cycles for 30 cycles → no capture, digits and valid unchanged.
- an=1100 or an=1111 with a legal seg held 20 cycles → no capture, no err, counter stays 0.
- Mid-frame: digits 0 and 1 captured, rst=1 for one edge → all outputs at reset values; digits 2 and 3 then captured → no frame_done until digits 0 and 1 are captured again.
